// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, with an empty-queue bypass
// and a flush that drops all prefetched words and invalidates the register.
module ir_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_instruction,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       ir_ce,
  input  logic                       flush,
  output logic [OP_W-1:0]            out_opcode,
  output logic [DATA_W-OP_W-1:0]     out_address,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = DATA_W - OP_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              valid_q, valid_d;

  logic empty, push, pop, bypass;

  assign in_ready = (count_q != CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = ir_ce && !empty && !flush;
  assign bypass   = ir_ce && empty && in_valid && !flush;
  // A bypassed word goes straight to the register and never occupies a slot.
  assign push     = in_valid && in_ready && !flush && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ir_d     = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (ir_ce) begin
        if (pop) begin
          ir_d    = mem_q[rd_ptr_q];
          valid_d = 1'b1;
        end else if (bypass) begin
          ir_d    = in_instruction;
          valid_d = 1'b1;
        end else begin
          // Starved load: fields keep their old value, only validity drops.
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ir_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is not reset; gate on rst_n so a word presented during reset is not written.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= in_instruction;
  end

  assign out_opcode  = ir_q[DATA_W-1 -: OP_W];
  assign out_address = ir_q[AddrW-1:0];
  assign out_valid   = valid_q;
  assign count       = count_q;

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: the driver queues the hand-computed post-edge state for
// every cycle it drives, and a monitor compares it against the outputs on the falling edge.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_instruction = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ir_ce = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  out_opcode;
  logic [11:0] out_address;
  logic        out_valid;
  logic [2:0]  count;

  typedef struct {
    string       name;
    logic [15:0] word;
    logic        valid;
    logic [2:0]  cnt;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ir_queue #(.DATA_W(16), .OP_W(4), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_instruction (in_instruction),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ir_ce          (ir_ce),
    .flush          (flush),
    .out_opcode     (out_opcode),
    .out_address    (out_address),
    .out_valid      (out_valid),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, required %0h", name, field, act, req);
    end
  endtask

  // Monitor: each falling edge that has a pending expectation checks the state
  // produced by the rising edge just before it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "opcode",  32'(out_opcode),  32'(e.word[15:12]));
        chk(e.name, "address", 32'(out_address), 32'(e.word[11:0]));
        chk(e.name, "valid",   32'(out_valid),   32'(e.valid));
        chk(e.name, "count",   32'(count),       32'(e.cnt));
        chk(e.name, "ready",   32'(in_ready),    32'(e.rdy));
      end
    end
  end

  // Drive one cycle and queue the state expected after the following rising edge.
  task automatic step(input string name, input logic rst, input logic iv,
                      input logic [15:0] instr, input logic ce, input logic fl,
                      input logic [15:0] ew, input logic ev, input logic [2:0] ec,
                      input logic er);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n          = rst;
    in_valid       = iv;
    in_instruction = instr;
    ir_ce          = ce;
    flush          = fl;
    e.name = name; e.word = ew; e.valid = ev; e.cnt = ec; e.rdy = er;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name        rst iv instr     ce fl  exp_word  v  cnt rdy
    step("reset0",    0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 0, 1);
    step("reset1",    0, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 0, 1);
    step("idle",      1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
    step("bypass",    1, 1, 16'h3ABC, 1, 0, 16'h3ABC, 1, 0, 1);
    step("hold",      1, 0, 16'h0000, 0, 0, 16'h3ABC, 1, 0, 1);
    // Fill to full, then try a fifth word.
    step("fill1",     1, 1, 16'h1001, 0, 0, 16'h3ABC, 1, 1, 1);
    step("fill2",     1, 1, 16'h2002, 0, 0, 16'h3ABC, 1, 2, 1);
    step("fill3",     1, 1, 16'h3003, 0, 0, 16'h3ABC, 1, 3, 1);
    step("fill4",     1, 1, 16'h4004, 0, 0, 16'h3ABC, 1, 4, 0);
    step("fill5",     1, 1, 16'h5005, 0, 0, 16'h3ABC, 1, 4, 0);
    step("drain1",    1, 0, 16'h0000, 1, 0, 16'h1001, 1, 3, 1);
    step("drain2",    1, 0, 16'h0000, 1, 0, 16'h2002, 1, 2, 1);
    step("drain3",    1, 0, 16'h0000, 1, 0, 16'h3003, 1, 1, 1);
    step("drain4",    1, 0, 16'h0000, 1, 0, 16'h4004, 1, 0, 1);
    // Simultaneous push/pop at count 2; write pointer wraps past DEPTH.
    step("pre1",      1, 1, 16'h5A01, 0, 0, 16'h4004, 1, 1, 1);
    step("pre2",      1, 1, 16'h6A02, 0, 0, 16'h4004, 1, 2, 1);
    step("pp1",       1, 1, 16'h7A03, 1, 0, 16'h5A01, 1, 2, 1);
    step("pp2",       1, 1, 16'h8A04, 1, 0, 16'h6A02, 1, 2, 1);
    step("pp3",       1, 1, 16'h9A05, 1, 0, 16'h7A03, 1, 2, 1);
    step("pp4",       1, 1, 16'hAA06, 1, 0, 16'h8A04, 1, 2, 1);
    step("pp5",       1, 1, 16'hBA07, 1, 0, 16'h9A05, 1, 2, 1);
    step("pp6",       1, 1, 16'hCA08, 1, 0, 16'hAA06, 1, 2, 1);
    step("ppdrain1",  1, 0, 16'h0000, 1, 0, 16'hBA07, 1, 1, 1);
    step("ppdrain2",  1, 0, 16'h0000, 1, 0, 16'hCA08, 1, 0, 1);
    // Flush with three queued words and a valid register.
    step("fq1",       1, 1, 16'hD001, 0, 0, 16'hCA08, 1, 1, 1);
    step("fq2",       1, 1, 16'hE002, 0, 0, 16'hCA08, 1, 2, 1);
    step("fq3",       1, 1, 16'hF003, 0, 0, 16'hCA08, 1, 3, 1);
    step("flush",     1, 1, 16'h7777, 1, 1, 16'h0000, 0, 0, 1);
    step("postflush", 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);
    // Empty load after a bypassed F123 keeps the fields.
    step("bypassF",   1, 1, 16'hF123, 1, 0, 16'hF123, 1, 0, 1);
    step("emptyload", 1, 0, 16'h0000, 1, 0, 16'hF123, 0, 0, 1);
    // Pop from full while offering a word: the word is refused.
    step("full1",     1, 1, 16'h1111, 0, 0, 16'hF123, 0, 1, 1);
    step("full2",     1, 1, 16'h2222, 0, 0, 16'hF123, 0, 2, 1);
    step("full3",     1, 1, 16'h3333, 0, 0, 16'hF123, 0, 3, 1);
    step("full4",     1, 1, 16'h4444, 0, 0, 16'hF123, 0, 4, 0);
    step("fullpop",   1, 1, 16'h5555, 1, 0, 16'h1111, 1, 3, 1);
    step("fdrain1",   1, 0, 16'h0000, 1, 0, 16'h2222, 1, 2, 1);
    step("fdrain2",   1, 0, 16'h0000, 1, 0, 16'h3333, 1, 1, 1);
    step("fdrain3",   1, 0, 16'h0000, 1, 0, 16'h4444, 1, 0, 1);
    step("fdrain4",   1, 0, 16'h0000, 1, 0, 16'h4444, 0, 0, 1);
    // Reset mid-stream discards queued words, overriding a flush and a load.
    step("mid1",      1, 1, 16'h6666, 0, 0, 16'h4444, 0, 1, 1);
    step("midrst",    0, 1, 16'h8888, 1, 1, 16'h0000, 0, 0, 1);
    step("midload",   1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
